// File: rtl/mv_result_drain.sv
// Result drain for the systolic matrix-vector chain: captures each node's result
// on its skewed cycle, pulses that node's clear, then streams results in index order.
module mv_result_drain #(
    parameter int NUM_NODES = 8,
    parameter int RES_W     = 25,
    parameter int IDX_W     = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       done_in,
    input  logic [NUM_NODES*RES_W-1:0] res_flat,
    output logic [NUM_NODES-1:0]       node_sclr,
    output logic                       busy,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [RES_W-1:0]           m_data,
    output logic [IDX_W-1:0]           m_idx,
    output logic                       m_last,
    output logic                       overflow_err
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [RES_W-1:0]     cap_q [NUM_NODES];
    logic [RES_W-1:0]     res_a [NUM_NODES];
    logic                 cap_en;
    logic [IDX_W-1:0]     cap_idx;
    logic [NUM_NODES-1:0] sclr_q, sclr_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;
    logic [RES_W-1:0]     data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_nxt;

    always_comb begin
        for (int k = 0; k < NUM_NODES; k++) begin
            res_a[k] = res_flat[k*RES_W +: RES_W];
        end
    end

    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        cap_idx = '0;
        sclr_d  = '0;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        idx_d   = idx_q;
        // A pulse arriving mid-pass is dropped but remembered as an error.
        err_d   = err_q | (done_in & busy_q);
        unique case (state_q)
            IDLE: begin
                if (done_in) begin
                    cap_en  = 1'b1;
                    cap_idx = '0;
                    sclr_d  = NUM_NODES'(1);
                    busy_d  = 1'b1;
                    if (NUM_NODES == 1) begin
                        state_d = DRAIN;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        data_d  = res_a[0];
                        last_d  = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                        cnt_d   = IDX_W'(1);
                    end
                end
            end
            CAPTURE: begin
                cap_en  = 1'b1;
                cap_idx = cnt_q;
                sclr_d  = NUM_NODES'(1) << cnt_q;
                if (cnt_q == LAST_IDX) begin
                    // Node 0 was captured at E0, so the first beat is ready now.
                    state_d = DRAIN;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    data_d  = cap_q[0];
                    last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = cap_q[idx_nxt];
                        last_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sclr_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            for (int k = 0; k < NUM_NODES; k++) begin
                cap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sclr_q  <= sclr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            if (cap_en) begin
                cap_q[cap_idx] <= res_a[cap_idx];
            end
        end
    end

    assign node_sclr    = sclr_q;
    assign busy         = busy_q;
    assign m_valid      = valid_q;
    assign m_data       = data_q;
    assign m_idx        = idx_q;
    assign m_last       = last_q;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_mv_result_drain.sv
// Directed bench for mv_result_drain: cycle-level model of the pass timeline
// plus literal expectations for beat order, values and error behaviour.
module tb_mv_result_drain;

    localparam int N  = 4;
    localparam int W  = 25;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           done_in = 1'b0;
    logic           m_ready = 1'b0;
    logic [N*W-1:0] res_flat = '0;
    logic [N-1:0]   node_sclr;
    logic           busy, m_valid, m_last, overflow_err;
    logic [W-1:0]   m_data;
    logic [IW-1:0]  m_idx;

    always #5 clk = ~clk;

    mv_result_drain #(.NUM_NODES(N), .RES_W(W), .IDX_W(IW)) dut (
        .clk(clk), .rstn(rstn), .done_in(done_in), .res_flat(res_flat),
        .node_sclr(node_sclr), .busy(busy), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .overflow_err(overflow_err)
    );

    int checks = 0;
    int errors = 0;

    // Model: pass timeline in absolute edge numbers.
    int           cyc = 0;
    bit           mb = 0;
    bit           merr = 0;
    int           e0 = 0;
    int           sent = 0;
    logic [W-1:0] cap [N];

    // Beats seen transferring (observed values from the sample before the edge).
    int           log_idx [$];
    logic [W-1:0] log_dat [$];
    int           log_cyc [$];
    int           obs_idx;
    logic [W-1:0] obs_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_valid();
        return mb && (cyc - e0 >= N - 1);
    endfunction

    function automatic logic [N-1:0] exp_sclr();
        logic [N-1:0] one;
        one = 1;
        if (mb && (cyc - e0 < N)) return one << (cyc - e0);
        return '0;
    endfunction

    function automatic logic [N*W-1:0] one_node(input int k, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[k*W +: W] = v;
        return r;
    endfunction

    task automatic check_all();
        chk("busy", 32'(busy), 32'(mb));
        chk("overflow_err", 32'(overflow_err), 32'(merr));
        chk("m_valid", 32'(m_valid), 32'(exp_valid()));
        chk("node_sclr", 32'(node_sclr), 32'(exp_sclr()));
        if (exp_valid()) begin
            chk("m_idx", 32'(m_idx), 32'(sent));
            chk("m_data", 32'(m_data), 32'(cap[sent]));
            chk("m_last", 32'(m_last), 32'(sent == N - 1));
        end else begin
            chk("m_idx_idle", 32'(m_idx), 32'h0);
            chk("m_last_idle", 32'(m_last), 32'h0);
        end
        obs_idx = int'(m_idx);
        obs_dat = m_data;
    endtask

    task automatic step(input logic din, input logic [N*W-1:0] res, input logic rdy);
        bit xfer, was_busy;
        done_in  = din;
        res_flat = res;
        m_ready  = rdy;
        @(posedge clk);
        xfer     = exp_valid() && rdy;
        was_busy = mb;
        if (xfer) begin
            log_idx.push_back(obs_idx);
            log_dat.push_back(obs_dat);
            log_cyc.push_back(cyc);
        end
        cyc++;
        if (din && was_busy) merr = 1;
        if (xfer) begin
            sent++;
            if (sent == N) mb = 0;
        end
        if (!was_busy && din) begin
            mb   = 1;
            e0   = cyc;
            sent = 0;
        end
        if (mb && (cyc - e0 < N)) cap[cyc - e0] = res[(cyc - e0)*W +: W];
        #1;
        check_all();
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(m_valid), 32'h0);
        chk("rst_sclr", 32'(node_sclr), 32'h0);
        chk("rst_data", 32'(m_data), 32'h0);
        chk("rst_idx", 32'(m_idx), 32'h0);
        chk("rst_last", 32'(m_last), 32'h0);
        chk("rst_err", 32'(overflow_err), 32'h0);
        mb   = 0;
        merr = 0;
        sent = 0;
        #2;
        rstn = 1'b1;
    endtask

    // Start a pass with node k = vals[k] presented at edge E0+k.
    task automatic capture_pass(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                input logic [W-1:0] v2, input logic [W-1:0] v3);
        logic [W-1:0] v [N];
        logic [N-1:0] one;
        one = 1;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int k = 0; k < N; k++) begin
            step(k == 0, one_node(k, v[k]), 1'b1);
            chk("lit_sclr", 32'(node_sclr), 32'(one << k));
        end
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < 60 && mb; i++) begin
            step(1'b0, '0, (mode == 0) ? 1'b1 : (i % 3 == 2));
        end
        chk("drain_done", 32'(busy), 32'h0);
    endtask

    task automatic check_log(input string name, input logic [W-1:0] v0,
                             input logic [W-1:0] v1, input logic [W-1:0] v2,
                             input logic [W-1:0] v3);
        logic [W-1:0] v [N];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        chk({name, "_nbeats"}, 32'(log_dat.size()), 32'(N));
        for (int i = 0; i < N && i < log_dat.size(); i++) begin
            chk({name, "_idx"}, 32'(log_idx[i]), 32'(i));
            chk({name, "_dat"}, 32'(log_dat[i]), 32'(v[i]));
        end
    endtask

    initial begin
        #1;
        chk("init_busy", 32'(busy), 32'h0);
        chk("init_valid", 32'(m_valid), 32'h0);
        @(negedge clk);
        do_reset();
        step(1'b0, '0, 1'b1);

        // T1 + T3: full-rate drain, beats on consecutive cycles from E0+3
        clear_log();
        capture_pass(25'd1, 25'd2, 25'd3, 25'd4);
        chk("t1_valid_e0p3", 32'(m_valid), 32'h1);
        chk("t1_data0", 32'(m_data), 32'h1);
        drain(0);
        check_log("t1", 25'd1, 25'd2, 25'd3, 25'd4);
        for (int i = 0; i < N && i < log_cyc.size(); i++) begin
            chk("t1_cycle", 32'(log_cyc[i] - e0), 32'(N - 1 + i));
        end
        step(1'b0, '0, 1'b1);

        // T2: ready 0,0,1 pattern
        clear_log();
        capture_pass(25'd1, 25'd2, 25'd3, 25'd4);
        drain(1);
        check_log("t2", 25'd1, 25'd2, 25'd3, 25'd4);

        // T4: sign bit pass-through
        clear_log();
        capture_pass(25'h0AAAAAA, 25'h1000000, 25'h1FFFFFF, 25'h0000005);
        drain(0);
        check_log("t4", 25'h0AAAAAA, 25'h1000000, 25'h1FFFFFF, 25'h0000005);

        // T5: done_in during DRAIN while stalled
        clear_log();
        capture_pass(25'd11, 25'd12, 25'd13, 25'd14);
        step(1'b1, '0, 1'b0);
        chk("t5_err_set", 32'(overflow_err), 32'h1);
        step(1'b0, '0, 1'b0);
        drain(0);
        check_log("t5", 25'd11, 25'd12, 25'd13, 25'd14);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        chk("t5_no_pass", 32'(busy), 32'h0);
        chk("t5_err_sticky", 32'(overflow_err), 32'h1);

        // T6: reset mid-DRAIN after beat 1, then a clean pass
        capture_pass(25'd21, 25'd22, 25'd23, 25'd24);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t6_idx_before_rst", 32'(m_idx), 32'h2);
        do_reset();
        step(1'b0, '0, 1'b1);
        clear_log();
        capture_pass(25'd31, 25'd32, 25'd33, 25'd34);
        drain(0);
        check_log("t6", 25'd31, 25'd32, 25'd33, 25'd34);
        chk("t6_err_clear", 32'(overflow_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
